// File: rtl/reduce_pkg.sv
// Shared types and helpers for the pipelined N-way bitwise reduction unit.
// Operator enum, identity and pairwise apply, plus tree geometry helpers.
package reduce_pkg;

  typedef enum logic [1:0] {
    OP_OR  = 2'b00,
    OP_AND = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_e;

  // Padding value that leaves a reduction unchanged.
  function automatic logic identity(op_e op);
    return (op == OP_AND);
  endfunction

  // NOR reduces as OR; the inversion happens once at the unit output.
  function automatic logic apply(op_e op, logic a, logic b);
    case (op)
      OP_AND:  return a & b;
      OP_XOR:  return a ^ b;
      default: return a | b;
    endcase
  endfunction

  function automatic int level_width(int width, int lvl);
    int w;
    w = width;
    for (int k = 0; k < lvl; k++) w = (w + 1) / 2;
    return w;
  endfunction

  // Bit offset of a level inside the flattened tree vector.
  function automatic int level_offset(int width, int lvl);
    int o;
    o = 0;
    for (int k = 0; k < lvl; k++) o += level_width(width, k);
    return o;
  endfunction

endpackage

// File: rtl/reduce_stage.sv
// One registered level of the reduction tree: halves the element count,
// padding an odd element with the operator identity.
module reduce_stage
  import reduce_pkg::*;
#(
  parameter  int IN_W  = 2,
  localparam int OUT_W = (IN_W + 1) / 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             vld_p0,
  input  op_e              op_p0,
  input  logic             last_p0,
  input  logic [IN_W-1:0]  data_p0,
  output logic             vld_p1,
  output op_e              op_p1,
  output logic             last_p1,
  output logic [OUT_W-1:0] data_p1
);

  logic [2*OUT_W-1:0] padded;
  logic [OUT_W-1:0]   red;

  always_comb begin
    padded = '0;
    padded[IN_W-1:0] = data_p0;
    if ((IN_W % 2) != 0) padded[2*OUT_W-1] = identity(op_p0);
  end

  always_comb begin
    red = '0;
    for (int i = 0; i < OUT_W; i++) red[i] = apply(op_p0, padded[2*i], padded[2*i+1]);
  end

  // p0 -> p1 boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      op_p1   <= OP_OR;
      last_p1 <= 1'b0;
      data_p1 <= '0;
    end else if (en) begin
      vld_p1  <= vld_p0;
      op_p1   <= op_p0;
      last_p1 <= last_p0;
      data_p1 <= red;
    end
  end

endmodule

// File: rtl/reduce_nway_pipe.sv
// Pipelined N-way bitwise reduction with multi-beat packet accumulation,
// valid/ready on both sides and a single global advance enable.
module reduce_nway_pipe
  import reduce_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_op,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_data,
  output logic [1:0]       out_op,
  output logic [CNT_W-1:0] out_beats
);

  localparam int LEVELS  = $clog2(WIDTH);
  localparam int TOTAL_W = level_offset(WIDTH, LEVELS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // The whole packet reduces with its first beat's op, so resolve it at entry.
  logic first_in;
  op_e  pkt_op;
  op_e  beat_op;

  assign beat_op = first_in ? op_e'(in_op) : pkt_op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_in <= 1'b1;
      pkt_op   <= OP_OR;
    end else if (in_valid && in_ready) begin
      first_in <= in_last;
      if (first_in) pkt_op <= op_e'(in_op);
    end
  end

  logic               vld_t  [LEVELS+1];
  op_e                op_t   [LEVELS+1];
  logic               last_t [LEVELS+1];
  logic [TOTAL_W-1:0] tree_data;

  assign vld_t[0]            = in_valid;
  assign op_t[0]             = beat_op;
  assign last_t[0]           = in_last;
  assign tree_data[WIDTH-1:0] = in_data;

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int IW = level_width(WIDTH, l);
    localparam int OW = level_width(WIDTH, l + 1);
    localparam int IO = level_offset(WIDTH, l);
    localparam int OO = level_offset(WIDTH, l + 1);

    reduce_stage #(.IN_W(IW)) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (adv),
      .vld_p0  (vld_t[l]),
      .op_p0   (op_t[l]),
      .last_p0 (last_t[l]),
      .data_p0 (tree_data[IO+IW-1:IO]),
      .vld_p1  (vld_t[l+1]),
      .op_p1   (op_t[l+1]),
      .last_p1 (last_t[l+1]),
      .data_p1 (tree_data[OO+OW-1:OO])
    );
  end

  logic             first_acc;
  logic             acc;
  op_e              acc_op;
  logic [CNT_W-1:0] cnt;
  logic             vld_acc;

  // tree -> accumulator boundary; the accumulator doubles as the output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_acc <= 1'b1;
      acc       <= 1'b0;
      acc_op    <= OP_OR;
      cnt       <= '0;
      vld_acc   <= 1'b0;
    end else if (adv) begin
      vld_acc <= vld_t[LEVELS] && last_t[LEVELS];
      if (vld_t[LEVELS]) begin
        first_acc <= last_t[LEVELS];
        if (first_acc) begin
          acc    <= tree_data[TOTAL_W-1];
          acc_op <= op_t[LEVELS];
          cnt    <= CNT_W'(1);
        end else begin
          acc <= apply(acc_op, acc, tree_data[TOTAL_W-1]);
          if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign out_valid = vld_acc;
  assign out_data  = (acc_op == OP_NOR) ? ~acc : acc;
  assign out_op    = acc_op;
  assign out_beats = cnt;

endmodule

// File: tb/tb_reduce_nway_pipe.sv
// Bench for reduce_nway_pipe: three instances (WIDTH 8, 16 with CNT_W 2, 5)
// driven through one shared port set, table vectors plus packet sequences.
module tb_reduce_nway_pipe;
  import reduce_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] in_data = '0;
  logic [1:0]  in_op = 2'b00;
  int          sel = 0;

  always #5 clk = ~clk;

  logic rdy0, ov0, od0, rdy1, ov1, od1, rdy2, ov2, od2;
  logic [1:0] oo0, oo1, oo2;
  logic [7:0] ob0, ob2;
  logic [1:0] ob1;

  reduce_nway_pipe #(.WIDTH(8), .CNT_W(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && (sel == 0)), .in_ready(rdy0),
    .in_data(in_data[7:0]), .in_op(in_op), .in_last(in_last), .out_valid(ov0),
    .out_ready((sel == 0) ? out_ready : 1'b1), .out_data(od0), .out_op(oo0), .out_beats(ob0)
  );

  reduce_nway_pipe #(.WIDTH(16), .CNT_W(2)) u_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && (sel == 1)), .in_ready(rdy1),
    .in_data(in_data), .in_op(in_op), .in_last(in_last), .out_valid(ov1),
    .out_ready((sel == 1) ? out_ready : 1'b1), .out_data(od1), .out_op(oo1), .out_beats(ob1)
  );

  reduce_nway_pipe #(.WIDTH(5), .CNT_W(8)) u_w5 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && (sel == 2)), .in_ready(rdy2),
    .in_data(in_data[4:0]), .in_op(in_op), .in_last(in_last), .out_valid(ov2),
    .out_ready((sel == 2) ? out_ready : 1'b1), .out_data(od2), .out_op(oo2), .out_beats(ob2)
  );

  logic       m_rdy, m_ov, m_od;
  logic [1:0] m_oo;
  logic [7:0] m_ob;

  always_comb begin
    m_rdy = rdy0; m_ov = ov0; m_od = od0; m_oo = oo0; m_ob = ob0;
    case (sel)
      1: begin m_rdy = rdy1; m_ov = ov1; m_od = od1; m_oo = oo1; m_ob = {6'd0, ob1}; end
      2: begin m_rdy = rdy2; m_ov = ov2; m_od = od2; m_oo = oo2; m_ob = ob2; end
      default: ;
    endcase
  end

  typedef struct packed {
    logic       d;
    logic [1:0] op;
    logic [7:0] beats;
  } exp_t;

  typedef struct {
    int          s;
    logic [15:0] d;
    logic [1:0]  op;
    bit          exp;
  } vec_t;

  exp_t sbq[$];
  vec_t vt[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   n_pop = 0;

  // packet model used to form expected op/beats
  bit         first_b = 1'b1;
  logic [1:0] pkt_op_b = 2'b00;
  int         beats_b = 0;
  int         cmax = 255;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && m_ov && out_ready) begin
      if (sbq.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_output: got data=%0d beats=%0d, required no result", m_od, m_ob);
      end else begin
        e = sbq.pop_front();
        n_pop++;
        chk("out_data", 32'(m_od), 32'(e.d));
        chk("out_op", 32'(m_oo), 32'(e.op));
        chk("out_beats", 32'(m_ob), 32'(e.beats));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [15:0] d, input logic [1:0] op, input bit last, input bit exp_d);
    int   t;
    exp_t e;
    t = 0;
    in_data = d; in_op = op; in_last = last; in_valid = 1'b1;
    @(negedge clk);
    while (!m_rdy && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!m_rdy) begin
      n_chk++;
      n_err++;
      $display("FAIL send_timeout: got in_ready=0 for %0d cycles, required 1", t);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (first_b) begin
      pkt_op_b = op;
      beats_b = 0;
    end
    if (beats_b < cmax) beats_b++;
    first_b = last;
    if (last) begin
      e.d = exp_d; e.op = pkt_op_b; e.beats = 8'(beats_b);
      sbq.push_back(e);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sbq.size() != 0 && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("drain_pending", 32'(sbq.size()), 0);
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic select(input int s);
    drain();
    sel = s;
    cmax = (s == 1) ? 3 : 255;
    #1;
  endtask

  task automatic latency(input string name, input logic [15:0] d, input int exp_n);
    int n;
    send(d, 2'b00, 1'b1, 1'b1);
    n = 1;
    while (!m_ov && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, 32'(n), 32'(exp_n));
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    int p0;

    vt.push_back('{0, 16'h00FF, 2'b00, 1'b1});
    vt.push_back('{0, 16'h0000, 2'b00, 1'b0});
    vt.push_back('{0, 16'h00AA, 2'b00, 1'b1});
    vt.push_back('{0, 16'h0011, 2'b00, 1'b1});
    vt.push_back('{1, 16'hFFFF, 2'b01, 1'b1});
    vt.push_back('{1, 16'hFFFE, 2'b01, 1'b0});
    vt.push_back('{1, 16'h0001, 2'b01, 1'b0});
    vt.push_back('{1, 16'hFFFF, 2'b10, 1'b0});
    vt.push_back('{1, 16'hFFFE, 2'b10, 1'b1});
    vt.push_back('{1, 16'h0001, 2'b10, 1'b1});
    vt.push_back('{1, 16'hFFFF, 2'b11, 1'b0});
    vt.push_back('{1, 16'hFFFE, 2'b11, 1'b0});
    vt.push_back('{1, 16'h0001, 2'b11, 1'b0});
    vt.push_back('{1, 16'h0000, 2'b11, 1'b1});
    vt.push_back('{1, 16'h0000, 2'b00, 1'b0});
    vt.push_back('{2, 16'h001F, 2'b01, 1'b1});
    vt.push_back('{2, 16'h0007, 2'b10, 1'b1});
    vt.push_back('{2, 16'h000F, 2'b01, 1'b0});
    vt.push_back('{2, 16'h001F, 2'b10, 1'b1});
    vt.push_back('{2, 16'h0000, 2'b11, 1'b1});
    vt.push_back('{2, 16'h0010, 2'b00, 1'b1});

    // reset state of every instance
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk("rst_in_ready", 32'(m_rdy), 1);
      chk("rst_out_valid", 32'(m_ov), 0);
      chk("rst_out_data", 32'(m_od), 0);
      chk("rst_out_op", 32'(m_oo), 0);
      chk("rst_out_beats", 32'(m_ob), 0);
    end
    sel = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single-beat vectors, back-to-back within each instance
    for (int i = 0; i < vt.size(); i++) begin
      if (vt[i].s != sel) select(vt[i].s);
      send(vt[i].d, vt[i].op, 1'b1, vt[i].exp);
    end
    drain();

    // first-result latency for each tree depth
    select(0);
    latency("latency_w8", 16'h0001, 4);
    select(1);
    latency("latency_w16", 16'h0100, 5);
    select(2);
    latency("latency_w5", 16'h0010, 4);

    // packet with in_op changed mid-packet, then a single beat right behind it
    select(1);
    send(16'h0000, 2'b00, 1'b0, 1'b0);
    send(16'h0000, 2'b01, 1'b0, 1'b0);
    send(16'h0004, 2'b10, 1'b1, 1'b1);
    send(16'hFFFE, 2'b10, 1'b1, 1'b1);
    drain();

    // beat counter saturates at 3 with CNT_W = 2
    for (int i = 0; i < 5; i++) send(16'hFFFF, 2'b01, 1'b0, 1'b0);
    send(16'hFFFF, 2'b01, 1'b1, 1'b1);
    drain();

    // consumer stall with four beats queued
    select(0);
    p0 = n_pop;
    out_ready = 1'b0;
    send(16'h00FF, 2'b00, 1'b1, 1'b1);
    send(16'h0000, 2'b00, 1'b1, 1'b0);
    send(16'h0001, 2'b00, 1'b1, 1'b1);
    send(16'h0000, 2'b00, 1'b1, 1'b0);
    repeat (5) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(m_rdy), 0);
      chk("stall_out_valid", 32'(m_ov), 1);
      chk("stall_out_data", 32'(m_od), 1);
      chk("stall_out_beats", 32'(m_ob), 1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();
    chk("stall_result_count", 32'(n_pop - p0), 4);

    // idle input with out_ready toggling
    for (int i = 0; i < 4; i++) begin
      out_ready = ~out_ready;
      @(negedge clk);
      chk("idle_out_valid", 32'(m_ov), 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;

    // reset in the middle of a packet discards it
    select(1);
    send(16'h0001, 2'b00, 1'b0, 1'b0);
    send(16'h0001, 2'b00, 1'b0, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(m_ov), 0);
    chk("midrst_out_data", 32'(m_od), 0);
    chk("midrst_out_beats", 32'(m_ob), 0);
    sbq.delete();
    first_b = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(16'h0000, 2'b00, 1'b1, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
